// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared codes, frame state encoding and helpers for the PS/2 key generator
package ps2_pkg;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_AA = 8'hAA;
  localparam logic [7:0] CODE_FA = 8'hFA;
  localparam logic [7:0] CODE_FE = 8'hFE;
  localparam logic [7:0] CODE_EE = 8'hEE;

  // Bytes of the pause sequence that follow its leading E1.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  // Keyboard status/ack bytes that never map to a key event.
  function automatic logic is_discard(input logic [7:0] code);
    return code inside {CODE_AA, CODE_FA, CODE_FE, CODE_EE, 8'h00, 8'hFF};
  endfunction

endpackage

// File: rtl/ps2_key_gen_if.sv
// rtl/ps2_key_gen_if.sv - PS/2 pin inputs and key event outputs of the key generator
interface ps2_key_gen_if;

  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic [7:0]  err_cnt;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  ps2_key,
    input  err_cnt
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output ps2_key,
    output err_cnt
  );

endinterface

// File: rtl/ps2_filter.sv
// rtl/ps2_filter.sv - two-flop synchronizer with optional glitch filter and falling-edge strobe
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  logic [1:0] r_sync;

  // PS/2 lines idle high, so the chain resets to 1.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], i_pin};
  end

  generate
    if (FILTER_LEN > 0) begin : g_filter
      localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

      logic [CW-1:0] r_cnt;
      logic          r_level;
      logic          r_fall;

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          r_cnt   <= '0;
          r_level <= 1'b1;
          r_fall  <= 1'b0;
        end else begin
          r_fall <= 1'b0;
          if (r_sync[1] == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_cnt   <= '0;
            r_level <= r_sync[1];
            r_fall  <= r_level;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign o_level = r_level;
      assign o_fall  = r_fall;
    end else begin : g_bare
      assign o_level = r_sync[1];
      assign o_fall  = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ps2_key_gen.sv
// rtl/ps2_key_gen.sv - PS/2 device-to-host frame receiver and set-2 key event decoder
module ps2_key_gen
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 10000
) (
  input  logic          Clk,
  input  logic          Rst_n,
  ps2_key_gen_if.slave  ps2
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic         w_fall;
  logic         w_data;
  logic         w_clk_level_unused;
  logic         w_data_fall_unused;
  logic         w_timeout;
  logic         w_byte_ok;
  logic         w_byte_bad;
  frame_state_t r_state;
  frame_state_t w_state_nxt;
  logic [2:0]   r_bit_cnt;
  logic [7:0]   r_shift;
  logic         r_parity;
  logic [TW-1:0] r_to_cnt;
  logic         r_byte_valid;
  logic [7:0]   r_byte;
  logic [7:0]   r_err_cnt;
  logic         r_rel;
  logic         r_ext;
  logic [2:0]   r_skip;
  logic [10:0]  r_key;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .i_pin   (ps2.ps2_clk),
    .o_level (w_clk_level_unused),
    .o_fall  (w_fall)
  );

  ps2_filter #(.FILTER_LEN(0)) u_data_sync (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .i_pin   (ps2.ps2_data),
    .o_level (w_data),
    .o_fall  (w_data_fall_unused)
  );

  assign w_timeout = (r_state != IDLE) && (r_to_cnt >= TW'(TIMEOUT));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_byte_ok   = 1'b0;
    w_byte_bad  = 1'b0;
    if (w_fall) begin
      case (r_state)
        IDLE:    if (!w_data) w_state_nxt = DATA;
        DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        PARITY:  w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
          // Odd parity: data bits plus parity bit carry an odd number of ones.
          if (w_data && (^{r_shift, r_parity})) w_byte_ok  = 1'b1;
          else                                  w_byte_bad = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_byte_valid <= w_byte_ok;
      if (w_byte_ok) r_byte <= r_shift;
      if (w_byte_bad && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_fall) begin
        case (r_state)
          IDLE:   r_bit_cnt <= '0;
          DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: r_parity <= w_data;
          default: ;
        endcase
      end
      if ((r_state == IDLE) || w_fall) r_to_cnt <= '0;
      else if (!w_timeout)             r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Prefix flags accumulate across bytes and are consumed by the next key code.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_key  <= '0;
      r_rel  <= 1'b0;
      r_ext  <= 1'b0;
      r_skip <= '0;
    end else if (r_byte_valid) begin
      if (r_skip != 3'd0) begin
        r_skip <= r_skip - 3'd1;
      end else if (r_byte == CODE_E1) begin
        r_skip <= PAUSE_SKIP;
        r_rel  <= 1'b0;
        r_ext  <= 1'b0;
      end else if (r_byte == CODE_E0) begin
        r_ext <= 1'b1;
      end else if (r_byte == CODE_F0) begin
        r_rel <= 1'b1;
      end else if (is_discard(r_byte)) begin
        r_rel <= 1'b0;
        r_ext <= 1'b0;
      end else begin
        r_key <= {~r_key[10], ~r_rel, r_ext, r_byte};
        r_rel <= 1'b0;
        r_ext <= 1'b0;
      end
    end
  end

  assign ps2.ps2_key = r_key;
  assign ps2.err_cnt = r_err_cnt;

endmodule
